blink_seq: RTL and testbench

BLINK_SEQ -- requirements
Module: blink_seq

---
 rtl/blink_seq.sv | 152 +++++++++++++++
 tb/tb_blink_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/blink_seq.sv
// blink_seq: gates an upstream blink square wave with a per-step on/off pattern.
// The pattern advances one step per tick, with optional PWM dimming.
// Latency: led_out and wrap_pulse are registered, so they appear one cycle after their inputs are sampled.
// Backpressure: in RUN, cfg_ready drops while a configuration is pending; the pending entry is applied on the next wrap.
//
// Ports:
//   clk, rst_n           single clock, asynchronous active-low reset
//   tick_in              one-cycle step strobe (advances step_idx in RUN)
//   led_in               upstream blink square wave
//   cfg_valid/cfg_ready  pattern handshake; cfg_data (bit n = step n) and cfg_duty are sampled together
//   led_out              registered LED drive
//   step_idx             current step
//   wrap_pulse           one-cycle strobe after wrapping from step STEPS-1 to step 0
//
// Build option: define BLINK_SEQ_PWM_EN to compile in the PWM dimming counter and the duty registers.
// Without it, cfg_duty is ignored and the LED is never dimmed.
module blink_seq #(
  parameter int STEPS    = 8,
  parameter int PWM_BITS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tick_in,
  input  logic                     led_in,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [STEPS-1:0]         cfg_data,
  input  logic [PWM_BITS-1:0]      cfg_duty,
  output logic                     led_out,
  output logic [$clog2(STEPS)-1:0] step_idx,
  output logic                     wrap_pulse
);

  localparam int SW = $clog2(STEPS);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [STEPS-1:0] pattern;
  logic [STEPS-1:0] pend_pattern;
  logic             pend;
  logic             pwm_on;

  logic accept;
  logic at_last;
  logic wrap_tick;
  logic apply_pend;

  // IDLE always accepts. RUN accepts only while the pending slot is free.
  assign cfg_ready  = (state == IDLE) || !pend;
  assign accept     = cfg_valid && cfg_ready;
  assign at_last    = (step_idx == SW'(STEPS - 1));
  assign wrap_tick  = (state == RUN) && tick_in && at_last;
  // accept and apply_pend are mutually exclusive.
  // RUN accepts only while pend is low, and apply_pend requires pend high.
  assign apply_pend = wrap_tick && pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && (cfg_data != '0)) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        // An all-zero pattern applied at the wrap stops the sequencer.
        if (apply_pend && (pend_pattern == '0)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern      <= '0;
      pend_pattern <= '0;
      pend         <= 1'b0;
      step_idx     <= '0;
      led_out      <= 1'b0;
      wrap_pulse   <= 1'b0;
    end else begin
      wrap_pulse <= wrap_tick;
      led_out    <= (state == RUN) && pattern[step_idx] && led_in && pwm_on;

      if (state == IDLE) begin
        step_idx <= '0;
        if (accept) begin
          pattern <= cfg_data;
        end
      end else begin
        if (tick_in) begin
          step_idx <= at_last ? '0 : step_idx + SW'(1);
        end
        if (apply_pend) begin
          pattern <= pend_pattern;
          pend    <= 1'b0;
        end
        if (accept) begin
          pend_pattern <= cfg_data;
          pend         <= 1'b1;
        end
      end
    end
  end

`ifdef BLINK_SEQ_PWM_EN
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty;
  logic [PWM_BITS-1:0] pend_duty;

  // The counter runs in every state, so the dimming phase is independent of the pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt   <= '0;
      duty      <= '0;
      pend_duty <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (state == IDLE) begin
        if (accept) begin
          duty <= cfg_duty;
        end
      end else begin
        if (apply_pend) begin
          duty <= pend_duty;
        end
        if (accept) begin
          pend_duty <= cfg_duty;
        end
      end
    end
  end

  assign pwm_on = (pwm_cnt < duty);
`else
  logic unused_duty;
  assign unused_duty = ^cfg_duty;
  assign pwm_on      = 1'b1;
`endif

endmodule

// File: tb/tb_blink_seq.sv
// tb_blink_seq: randomized and directed stimulus for blink_seq.
// Every cycle is compared against a step-list reference model.
module tb_blink_seq;

  localparam int STEPS    = 8;
  localparam int PWM_BITS = 4;
  localparam int SW       = $clog2(STEPS);

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                tick_in = 1'b0;
  logic                led_in = 1'b0;
  logic                cfg_valid = 1'b0;
  logic                cfg_ready;
  logic [STEPS-1:0]    cfg_data = '0;
  logic [PWM_BITS-1:0] cfg_duty = '0;
  logic                led_out;
  logic [SW-1:0]       step_idx;
  logic                wrap_pulse;

  blink_seq #(.STEPS(STEPS), .PWM_BITS(PWM_BITS)) dut (
    .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .led_in(led_in),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .cfg_duty(cfg_duty), .led_out(led_out), .step_idx(step_idx),
    .wrap_pulse(wrap_pulse)
  );

  initial forever #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model state: whether the sequencer is running, the active and queued patterns,
  // the step position, and the free-running dimming phase.
  bit              m_run;
  bit [STEPS-1:0]  m_pat;
  bit [STEPS-1:0]  m_pend_pat;
  bit              m_pend;
  int              m_duty;
  int              m_pend_duty;
  int              m_step;
  int              m_pwm;
  bit              m_led;
  bit              m_wrap;

  function automatic bit exp_ready();
    return !m_run || !m_pend;
  endfunction

  task automatic model_reset();
    m_run = 0; m_pat = '0; m_pend_pat = '0; m_pend = 0; m_duty = 0;
    m_pend_duty = 0; m_step = 0; m_pwm = 0; m_led = 0; m_wrap = 0;
  endtask

  task automatic model_update(input bit t, input bit l, input bit v,
                              input bit [STEPS-1:0] d, input int du);
    bit acc;
    bit pwm_on;
    acc    = v && exp_ready();
    pwm_on = 1;
`ifdef BLINK_SEQ_PWM_EN
    pwm_on = (m_pwm < m_duty);
`endif
    m_led  = m_run && m_pat[m_step] && l && pwm_on;
    m_wrap = m_run && t && (m_step == STEPS - 1);
    if (!m_run) begin
      if (acc) begin
        m_pat  = d;
        m_duty = du;
        m_run  = (d != 0);
        m_step = 0;
      end
    end else begin
      if (t) begin
        m_step = (m_step + 1) % STEPS;
        if (m_step == 0 && m_pend) begin
          m_pat  = m_pend_pat;
          m_duty = m_pend_duty;
          m_pend = 0;
          if (m_pat == 0) begin
            m_run  = 0;
            m_step = 0;
          end
        end
      end
      if (acc) begin
        m_pend      = 1;
        m_pend_pat  = d;
        m_pend_duty = du;
      end
    end
    m_pwm = (m_pwm + 1) % (1 << PWM_BITS);
  endtask

  // One clock cycle: drive inputs at the falling edge, then check the outputs 1 time unit after the rising edge.
  task automatic cyc(input bit t, input bit l, input bit v,
                     input bit [STEPS-1:0] d, input int du);
    @(negedge clk);
    tick_in = t; led_in = l; cfg_valid = v; cfg_data = d; cfg_duty = du[PWM_BITS-1:0];
    #1;
    chk("cfg_ready", {31'd0, cfg_ready}, {31'd0, exp_ready()});
    model_update(t, l, v, d, du);
    @(posedge clk);
    #1;
    chk("led_out", {31'd0, led_out}, {31'd0, m_led});
    chk("step_idx", 32'(step_idx), 32'(m_step));
    chk("wrap_pulse", {31'd0, wrap_pulse}, {31'd0, m_wrap});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    tick_in = 1'b1;
    #1;
    chk("rst_led", {31'd0, led_out}, 32'd0);
    chk("rst_step", 32'(step_idx), 32'd0);
    chk("rst_wrap", {31'd0, wrap_pulse}, 32'd0);
    chk("rst_ready", {31'd0, cfg_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  int wraps;
  int highs;

  initial begin
    model_reset();
    do_reset();
    // The first tick after reset release must be ignored.
    cyc(1, 1, 0, '0, 0);

    // Pattern A5 at full duty: eight ticks give one full pass and exactly one wrap.
    cyc(0, 1, 1, 8'hA5, 15);
    wraps = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1, 1, 0, '0, 0);
      wraps += int'(wrap_pulse);
    end
    cyc(0, 1, 0, '0, 0);
    wraps += int'(wrap_pulse);
    chk("a5_wraps", 32'(wraps), 32'd1);
    for (int i = 0; i < 8; i++) cyc(1, i % 3 != 0, 0, '0, 0);

    // Offer FF at step 3. A second offer while FF is pending must be stalled.
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, '0, 0);
    cyc(0, 1, 1, 8'hFF, 15);
    cyc(0, 1, 1, 8'h0F, 15);
    chk("stall_ready", {31'd0, cfg_ready}, 32'd0);
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, '0, 0);
    chk("ready_after_wrap", {31'd0, cfg_ready}, 32'd1);
    for (int i = 0; i < 8; i++) cyc(1, 1, 0, '0, 0);

    // A handshake in the same cycle as the wrap tick waits one full pass before taking effect.
    for (int i = 0; i < 7; i++) cyc(1, 1, 0, '0, 0);
    cyc(1, 1, 1, 8'h3C, 15);
    for (int i = 0; i < 16; i++) cyc(1, 1, 0, '0, 0);

    // A queued all-zero pattern stops the sequencer at the wrap.
    cyc(1, 1, 1, 8'h00, 15);
    for (int i = 0; i < 7; i++) cyc(1, 1, 0, '0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, '0, 0);
    chk("zero_idle_step", 32'(step_idx), 32'd0);
    chk("zero_idle_led", {31'd0, led_out}, 32'd0);

    // Reset at step 5 while a pattern is pending. Both configurations must be discarded.
    cyc(0, 1, 1, 8'h81, 15);
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, '0, 0);
    cyc(0, 1, 1, 8'h11, 15);
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1, 1, 0, '0, 0);
    chk("post_rst_step", 32'(step_idx), 32'd0);

    // Dimming: with duty 4 the LED is lit 4 of every 16 cycles (always lit without dimming).
    cyc(0, 1, 1, 8'hFF, 4);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, '0, 0);
    highs = 0;
    for (int i = 0; i < 32; i++) begin
      cyc(0, 1, 0, '0, 0);
      highs += int'(led_out);
    end
`ifdef BLINK_SEQ_PWM_EN
    chk("pwm_highs", 32'(highs), 32'd8);
`else
    chk("pwm_highs", 32'(highs), 32'd32);
`endif

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      bit [STEPS-1:0] d;
      d = ($urandom_range(0, 7) == 0) ? '0 : STEPS'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
          $urandom_range(0, 7) == 0, d, int'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
